// File: rtl/int_to_float_param.sv
// int_to_float_param: integer-to-float converter with configurable widths.
// It accepts signed or unsigned operands, supports four rounding modes and
// reports inexact results. The normaliser is iterative and shifts one bit per
// cycle. Only one conversion is in flight at a time.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   input_a         integer operand (INT_W bits)
//   input_a_signed  1 = two's complement operand, 0 = unsigned
//   input_a_round   0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf
//   input_a_stb/ack operand handshake; transfer when both are high on an edge
//   output_z        {sign, biased exponent, fraction}
//   output_inexact  the result was rounded; valid together with output_z
//   output_z_stb/ack result handshake; transfer when both are high on an edge
module int_to_float_param #(
    parameter int unsigned INT_W = 32,
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INT_W-1:0]       input_a,
    input  logic                   input_a_signed,
    input  logic [1:0]             input_a_round,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic                   output_inexact,
    output logic                   output_z_stb,
    input  logic                   output_z_ack
);

    localparam int unsigned EXT_W = INT_W + MAN_W + 2;
    localparam logic [EXP_W-1:0] BIAS  = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0] E_TOP = EXP_W'(INT_W - 1);

    typedef enum logic [2:0] {StIdle, StAbs, StNorm, StRound, StPack, StOut} state_e;

    state_e               state_q, state_d;
    logic [INT_W-1:0]     mag_q, mag_d;
    logic                 signed_q, signed_d;
    logic [1:0]           rnd_q, rnd_d;
    logic                 sign_q, sign_d;
    logic                 zero_q, zero_d;
    logic [EXP_W-1:0]     exp_q, exp_d;
    logic [MAN_W-1:0]     frac_q, frac_d;
    logic                 rinexact_q, rinexact_d;
    logic                 ack_q, ack_d;
    logic [EXP_W+MAN_W:0] z_q, z_d;
    logic                 zinexact_q, zinexact_d;
    logic                 zstb_q, zstb_d;

    // Rounding datapath. Padding mag with zeros on the right keeps the slice
    // positions fixed for any INT_W; a narrow operand then gets g = s = 0.
    logic [EXT_W-1:0]     ext;
    logic [MAN_W:0]       m;
    logic                 g, s, inc;
    logic [MAN_W+1:0]     m_sum;
    logic                 neg_now;
    logic [INT_W-1:0]     abs_val;

    always_comb begin
        ext   = {mag_q, {(MAN_W+2){1'b0}}};
        m     = ext[EXT_W-1 -: MAN_W+1];
        g     = ext[INT_W];
        s     = |ext[INT_W-1:0];
        unique case (rnd_q)
            2'd0:    inc = g & (s | m[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = ~sign_q & (g | s);
            default: inc = sign_q & (g | s);
        endcase
        m_sum   = {1'b0, m} + {{(MAN_W+1){1'b0}}, inc};
        neg_now = signed_q & mag_q[INT_W-1];
        // The most-negative value negates to 2^(INT_W-1), which is exact as unsigned.
        abs_val = neg_now ? (~mag_q + {{(INT_W-1){1'b0}}, 1'b1}) : mag_q;
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        signed_d   = signed_q;
        rnd_d      = rnd_q;
        sign_d     = sign_q;
        zero_d     = zero_q;
        exp_d      = exp_q;
        frac_d     = frac_q;
        rinexact_d = rinexact_q;
        ack_d      = ack_q;
        z_d        = z_q;
        zinexact_d = zinexact_q;
        zstb_d     = zstb_q;

        unique case (state_q)
            StIdle: begin
                ack_d = 1'b1;
                if (input_a_stb && ack_q) begin
                    mag_d    = input_a;
                    signed_d = input_a_signed;
                    rnd_d    = input_a_round;
                    ack_d    = 1'b0;
                    state_d  = StAbs;
                end
            end
            StAbs: begin
                mag_d  = abs_val;
                exp_d  = E_TOP;
                zero_d = (abs_val == '0);
                // A zero result is +0 even for signed operands.
                sign_d = neg_now;
                state_d = (abs_val == '0) ? StPack : StNorm;
            end
            StNorm: begin
                if (mag_q[INT_W-1]) begin
                    state_d = StRound;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - {{(EXP_W-1){1'b0}}, 1'b1};
                end
            end
            StRound: begin
                // A carry out of an all-ones mantissa leaves a zero fraction
                // and bumps the exponent.
                frac_d     = m_sum[MAN_W-1:0];
                exp_d      = exp_q + {{(EXP_W-1){1'b0}}, m_sum[MAN_W+1]};
                rinexact_d = g | s;
                state_d    = StPack;
            end
            StPack: begin
                z_d        = zero_q ? '0 : {sign_q, exp_q + BIAS, frac_q};
                zinexact_d = zero_q ? 1'b0 : rinexact_q;
                zstb_d     = 1'b1;
                state_d    = StOut;
            end
            StOut: begin
                if (zstb_q && output_z_ack) begin
                    zstb_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mag_q      <= '0;
            signed_q   <= 1'b0;
            rnd_q      <= 2'd0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
            exp_q      <= '0;
            frac_q     <= '0;
            rinexact_q <= 1'b0;
            ack_q      <= 1'b0;
            z_q        <= '0;
            zinexact_q <= 1'b0;
            zstb_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            signed_q   <= signed_d;
            rnd_q      <= rnd_d;
            sign_q     <= sign_d;
            zero_q     <= zero_d;
            exp_q      <= exp_d;
            frac_q     <= frac_d;
            rinexact_q <= rinexact_d;
            ack_q      <= ack_d;
            z_q        <= z_d;
            zinexact_q <= zinexact_d;
            zstb_q     <= zstb_d;
        end
    end

    assign input_a_ack    = ack_q;
    assign output_z       = z_q;
    assign output_inexact = zinexact_q;
    assign output_z_stb   = zstb_q;

endmodule
